// File: rtl/mp3_fetch_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mp3_fetch_controller
//  Purpose  : Arbitrates one RAM port between host accesses and MP3 prefetch
//             into a small first-word-fall-through FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module mp3_fetch_controller #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LOW_WATER  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  addrWrite,
    input  logic [ADDR_WIDTH-1:0] addrWData,
    output logic                  feederReady,
    output logic [ADDR_WIDTH-1:0] feederAddr,
    input  logic                  hostReq,
    input  logic                  hostWrite,
    input  logic [ADDR_WIDTH-1:0] hostAddr,
    input  logic [DATA_WIDTH-1:0] hostWData,
    output logic [DATA_WIDTH-1:0] hostRData,
    output logic                  hostAck,
    output logic                  ramReq,
    output logic                  ramWrite,
    output logic [ADDR_WIDTH-1:0] ramAddr,
    output logic [DATA_WIDTH-1:0] ramWData,
    input  logic [DATA_WIDTH-1:0] ramRData,
    input  logic                  ramAck,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataReady,
    input  logic                  dataAck
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    localparam logic [c_LVL_W-1:0]    c_DEPTH     = c_LVL_W'(FIFO_DEPTH);
    localparam logic [c_LVL_W-1:0]    c_LOW_WATER = c_LVL_W'(LOW_WATER);
    localparam logic [c_LVL_W-1:0]    c_LVL_ONE   = c_LVL_W'(1);
    localparam logic [c_PTR_W-1:0]    c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = ADDR_WIDTH'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_HOST  = 2'd1;
    localparam logic [1:0] c_FETCH = 2'd2;

    logic [1:0]            r_state;
    logic [c_LVL_W-1:0]    r_level;
    logic [c_PTR_W-1:0]    r_wrPtr;
    logic [c_PTR_W-1:0]    r_rdPtr;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic w_fetchWanted;
    logic w_hostPending;
    logic w_hostGrant;
    logic w_seek;
    logic w_push;
    logic w_pop;

    // hostReq is still high during the hostAck cycle; it belongs to the
    // request just completed and must not trigger a second grant.
    assign w_hostPending = hostReq & ~hostAck;
    assign w_fetchWanted = enable & (r_level < c_DEPTH) & ~addrWrite;
    assign w_hostGrant   = w_hostPending & (~w_fetchWanted | (r_level > c_LOW_WATER));

    assign w_seek = addrWrite & (r_state != c_FETCH);
    assign w_push = (r_state == c_FETCH) & ramAck;
    assign w_pop  = dataAck & (r_level != '0);

    assign feederReady = (r_state != c_FETCH);
    assign dataReady   = (r_level != '0);
    assign dataOut     = r_mem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            feederAddr <= '0;
            ramReq     <= 1'b0;
            ramWrite   <= 1'b0;
            ramAddr    <= '0;
            ramWData   <= '0;
            hostRData  <= '0;
            hostAck    <= 1'b0;
            r_level    <= '0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
        end else begin
            hostAck <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_hostGrant) begin
                        r_state  <= c_HOST;
                        ramReq   <= 1'b1;
                        ramWrite <= hostWrite;
                        ramAddr  <= hostAddr;
                        ramWData <= hostWData;
                    end else if (w_fetchWanted) begin
                        r_state  <= c_FETCH;
                        ramReq   <= 1'b1;
                        ramWrite <= 1'b0;
                        ramAddr  <= feederAddr;
                        ramWData <= '0;
                    end
                end
                c_HOST: begin
                    if (ramAck) begin
                        r_state   <= c_IDLE;
                        ramReq    <= 1'b0;
                        ramWrite  <= 1'b0;
                        hostAck   <= 1'b1;
                        hostRData <= ramRData;
                    end
                end
                c_FETCH: begin
                    if (ramAck) begin
                        r_state    <= c_IDLE;
                        ramReq     <= 1'b0;
                        feederAddr <= feederAddr + c_ADDR_ONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    ramReq  <= 1'b0;
                end
            endcase

            // A seek is never accepted in FETCH, so it cannot collide with
            // the address increment above.
            if (w_seek) begin
                feederAddr <= addrWData;
                r_level    <= '0;
                r_wrPtr    <= '0;
                r_rdPtr    <= '0;
            end else begin
                if (w_push) r_wrPtr <= r_wrPtr + c_PTR_ONE;
                if (w_pop)  r_rdPtr <= r_rdPtr + c_PTR_ONE;
                if (w_push && !w_pop)
                    r_level <= r_level + c_LVL_ONE;
                else if (!w_push && w_pop)
                    r_level <= r_level - c_LVL_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wrPtr] <= ramRData;
    end

endmodule
`default_nettype wire

// File: doc/mp3_fetch_controller.md
MP3_FETCH_CONTROLLER -- requirements
Module: mp3_fetch_controller

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24: word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: RAM/FIFO word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2): prefetch FIFO entries.
REQ-004 SHALL have parameter LOW_WATER, default 1: FIFO level at or below which MP3 fetch has priority.
REQ-005 SHALL have these ports (name  direction  width  meaning):
clk  in  1  single clock, all logic on rising edge.
reset  in  1  synchronous, active-low reset.
enable  in  1  fetching permitted (playback active).
addrWrite  in  1  seek request (load new fetch address).
addrWData  in  ADDR_WIDTH  seek address.
feederReady  out  1  seek may be accepted this cycle.
feederAddr  out  ADDR_WIDTH  address of next word to fetch.
hostReq  in  1  host RAM access request, held until hostAck.
hostWrite  in  1  host access is write.
hostAddr  in  ADDR_WIDTH  host address.
hostWData  in  DATA_WIDTH  host write data.
hostRData  out  DATA_WIDTH  host read data, valid with hostAck.
hostAck  out  1  one-cycle host completion pulse.
ramReq  out  1  RAM request, held until ramAck.
ramWrite  out  1  RAM access is write.
ramAddr  out  ADDR_WIDTH  RAM address.
ramWData  out  DATA_WIDTH  RAM write data.
ramRData  in  DATA_WIDTH  RAM read data, valid with ramAck.
ramAck  in  1  RAM completion pulse.
dataOut  out  DATA_WIDTH  FIFO head word (to descrambler).
dataReady  out  1  FIFO non-empty.
dataAck  in  1  consumer pops head word.

Function
REQ-006 SHALL implement states IDLE, HOST, FETCH; ramReq high exactly in HOST and FETCH.
REQ-007 In IDLE, SHALL evaluate grant each cycle: fetchWanted = enable & (level < FIFO_DEPTH) & ~addrWrite.
REQ-008 If hostReq and fetchWanted and level > LOW_WATER, SHALL enter HOST; if level <= LOW_WATER, SHALL enter FETCH.
REQ-009 If only one of hostReq/fetchWanted is set, SHALL enter the corresponding state; neither -> stay IDLE.
REQ-010 Arbitration SHALL be non-preemptive: ramAddr/ramWrite/ramWData latched on state entry and held stable until ramAck.
REQ-011 On ramAck in HOST, SHALL pulse hostAck one cycle later with hostRData = captured ramRData, return to IDLE.
REQ-012 On ramAck in FETCH, SHALL push ramRData into FIFO, increment feederAddr by 1 (modulo 2^ADDR_WIDTH, wrap to 0), return to IDLE.
REQ-013 Minimum spacing between RAM grants SHALL be one IDLE cycle after each ramAck.
REQ-014 feederReady SHALL equal (state != FETCH); addrWrite while feederReady low SHALL be ignored.
REQ-015 Accepted addrWrite SHALL load feederAddr = addrWData and flush FIFO (level 0, dataReady low) next cycle; simultaneous dataAck is discarded.
REQ-016 FIFO SHALL be first-word-fall-through; dataAck with dataReady low SHALL be ignored.
REQ-017 Simultaneous push and pop SHALL leave level unchanged; pop when empty and push when full SHALL never occur (guaranteed by REQ-007).
REQ-018 enable deasserting during FETCH SHALL not abort it; the word is still pushed.
REQ-019 hostAck SHALL never be issued without a prior hostReq grant; hostReq dropped mid-HOST is a protocol violation (undefined).

Reset
REQ-020 With reset low at a clk edge: state IDLE, feederAddr 0, FIFO level 0, ramReq/ramWrite/hostAck/dataReady 0, feederReady 1, ramAddr/ramWData/hostRData 0.
REQ-021 Reset asserted mid-transaction SHALL abandon it: no hostAck, no FIFO push from a later ramAck.

Verification
REQ-022 Seek 0x000100, enable=1, RAM acks after 2 cycles with data 0xA5A5.. -> ramAddr 0x000100,0x000101,... FIFO fills to 4, ramReq stops, feederAddr 0x000104.
REQ-023 FIFO level 3, hostReq held -> HOST granted, hostAck one cycle after ramAck; level 1 with hostReq -> FETCH granted first.
REQ-024 Seek 0xFFFFFE, fetch 3 words -> addresses 0xFFFFFE, 0xFFFFFF, 0x000000.
REQ-025 addrWrite during FETCH -> ignored, feederAddr advances; addrWrite in IDLE with level 3 and dataAck -> level 0, feederAddr = new value.
REQ-026 reset low during FETCH, then ramAck -> no push, dataReady 0, state IDLE, feederAddr 0.
